serial_receiver: RTL and testbench

Serial-to-parallel frame receiver. It is the receive end of the single-wire serial link driven by the team's shift-register serial output: LSB first, one bit per clock. It detects a start bit, shifts in N data bits, and checks the stop bit. Each received word is presented on a registered parallel port with a valid/ready handshake. It sits between the serial link pin logic and the parallel consumer, and flags framing errors and overruns.

---
 rtl/serial_receiver.sv | 77 +++++++
 tb/tb_serial_receiver.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/serial_receiver.sv
// rtl/serial_receiver.sv - serial-to-parallel frame receiver with valid/ready output
module serial_receiver #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         serial_in,
    input  logic         data_ready,
    output logic [N-1:0] data_out,
    output logic         data_valid,
    output logic         busy,
    output logic         framing_error,
    output logic         overrun
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] bit_cnt;
    logic [N-1:0]  shreg;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shreg         <= '0;
            data_out      <= '0;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            framing_error <= 1'b0;
            overrun       <= 1'b0;
            if (data_valid && data_ready)
                data_valid <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (!serial_in) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    // LSB arrives first, so after N shifts bit 0 sits at shreg[0]
                    shreg <= {serial_in, shreg[N-1:1]};
                    if (bit_cnt == CW'(N - 1))
                        state <= STOP;
                    else
                        bit_cnt <= bit_cnt + 1'b1;
                end
                STOP: begin
                    // A low stop bit is an error only; it is never reused as a start bit
                    state <= IDLE;
                    if (serial_in) begin
                        if (!data_valid || data_ready) begin
                            data_out   <= shreg;
                            data_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else begin
                        framing_error <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_receiver.sv
// tb/tb_serial_receiver.sv - self-checking bench for serial_receiver against a frame-level model
module tb_serial_receiver;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         serial_in;
    logic         data_ready;
    logic [N-1:0] data_out;
    logic         data_valid;
    logic         busy;
    logic         framing_error;
    logic         overrun;

    int tests = 0;
    int fails = 0;

    // Model of the output buffer: what the consumer should see
    logic         m_valid;
    logic [N-1:0] m_data;
    logic         m_fe;
    logic         m_ov;

    serial_receiver #(.N(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .serial_in     (serial_in),
        .data_ready    (data_ready),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .busy          (busy),
        .framing_error (framing_error),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input logic exp_busy);
        check("data_valid", 32'(data_valid), 32'(m_valid));
        check("data_out", 32'(data_out), 32'(m_data));
        check("framing_error", 32'(framing_error), 32'(m_fe));
        check("overrun", 32'(overrun), 32'(m_ov));
        check("busy", 32'(busy), 32'(exp_busy));
    endtask

    // One clock edge; stop_edge marks the edge that samples the stop bit of `word`
    task automatic edge1(input logic s, input logic r, input bit stop_edge,
                         input logic [N-1:0] word, input logic exp_busy);
        serial_in  = s;
        data_ready = r;
        @(posedge clk);
        m_fe = 1'b0;
        m_ov = 1'b0;
        if (stop_edge && s) begin
            if (!m_valid || r) begin
                m_data  = word;
                m_valid = 1'b1;
            end else begin
                m_ov = 1'b1;
            end
        end else begin
            if (stop_edge) m_fe = 1'b1;
            if (m_valid && r) m_valid = 1'b0;
        end
        #1;
        check_all(exp_busy);
    endtask

    function automatic logic pick_ready(input int mode, input bit is_stop);
        case (mode)
            0: return 1'b0;
            1: return 1'b1;
            3: return is_stop;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // mode: 0 ready low, 1 ready high, 2 random, 3 ready only on the stop edge
    task automatic send_frame(input logic [N-1:0] word, input logic stop_bit, input int mode);
        edge1(1'b0, pick_ready(mode, 0), 0, word, 1'b1);
        for (int i = 0; i < N; i++)
            edge1(word[i], pick_ready(mode, 0), 0, word, 1'b1);
        edge1(stop_bit, pick_ready(mode, 1), 1, word, 1'b0);
    endtask

    task automatic idle(input int cycles, input int mode);
        for (int i = 0; i < cycles; i++)
            edge1(1'b1, pick_ready(mode, 0), 0, '0, 1'b0);
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_fe    = 1'b0;
        m_ov    = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        serial_in  = 1'b1;
        data_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all(1'b0);
        rst = 1'b0;
        idle(3, 0);

        // Single frame, held until consumed
        send_frame(8'hA5, 1'b1, 0);
        idle(2, 0);
        idle(1, 1);
        idle(1, 0);

        // Back-to-back with ready held high
        send_frame(8'h3C, 1'b1, 1);
        send_frame(8'hFF, 1'b1, 1);

        // Framing error then a good frame
        send_frame(8'h12, 1'b0, 1);
        send_frame(8'h34, 1'b1, 0);
        idle(1, 1);

        // Overrun, then simultaneous consume and load
        send_frame(8'h11, 1'b1, 0);
        send_frame(8'h22, 1'b1, 0);
        idle(1, 1);
        send_frame(8'h11, 1'b1, 0);
        send_frame(8'h22, 1'b1, 3);
        idle(1, 1);

        // Reset mid-frame after 4 data bits
        edge1(1'b0, 1'b0, 0, '0, 1'b1);
        for (int i = 0; i < 4; i++)
            edge1(1'($urandom_range(0, 1)), 1'b0, 0, '0, 1'b1);
        rst = 1'b1;
        model_reset();
        #1;
        check_all(1'b0);
        @(posedge clk);
        #1;
        check_all(1'b0);
        rst = 1'b0;
        send_frame(8'h5A, 1'b1, 0);
        idle(1, 1);

        // Idle noise
        idle(50, 2);

        // Random frames, stop bits, handshakes and gaps
        for (int f = 0; f < 40; f++) begin
            send_frame(8'($urandom), ($urandom_range(0, 5) != 0), int'($urandom_range(0, 3)));
            idle(int'($urandom_range(0, 2)), 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
